// File: rtl/better_neighbor_scan.sv
// Scans a neighbour-cost memory and records the indices of neighbours cheaper than the current solution.
// Optional macro SCAN_TIE_BETTER_EN makes equal-cost neighbours count as better.
module better_neighbor_scan #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BUF_DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         nreset,
    input  logic                         start_scan,
    input  logic [DATA_W-1:0]            neighbor_total,
    input  logic [DATA_W-1:0]            current_cost,
    output logic                         mem_rd,
    output logic [DATA_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_data,
    output logic [DATA_W-1:0]            better_neighbor_count,
    output logic                         done_scan,
    input  logic [$clog2(BUF_DEPTH)-1:0] buf_index,
    output logic [DATA_W-1:0]            buf_addr
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam logic [DATA_W-1:0] DEPTH_VAL = DATA_W'(BUF_DEPTH);
    localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] idx;
    logic [DATA_W-1:0] total_q;
    logic [DATA_W-1:0] cost_q;
    logic              last;
    logic              better;
    logic              store;
    logic [DATA_W-1:0] slots [BUF_DEPTH];

    // total_q is never 0 outside IDLE/DONE, so total_q-1 cannot wrap while in CMP
    assign last = (idx == (total_q - ONE));

`ifdef SCAN_TIE_BETTER_EN
    assign better = (mem_data <= cost_q);
`else
    assign better = (mem_data < cost_q);
`endif

    assign store    = (state == CMP) && better && (better_neighbor_count != DEPTH_VAL);
    assign mem_rd   = (state == READ);
    assign buf_addr = slots[buf_index];

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_scan) begin
                    next_state = (neighbor_total == '0) ? DONE : READ;
                end
            end
            READ:    next_state = CMP;
            CMP:     next_state = last ? DONE : READ;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            idx                   <= '0;
            total_q               <= '0;
            cost_q                <= '0;
            mem_addr              <= '0;
            better_neighbor_count <= '0;
            done_scan             <= 1'b0;
        end else begin
            // Registered from DONE so the pulse lands one edge after the FSM reaches DONE
            done_scan <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start_scan) begin
                        idx                   <= '0;
                        total_q               <= neighbor_total;
                        cost_q                <= current_cost;
                        better_neighbor_count <= '0;
                        if (neighbor_total != '0) begin
                            mem_addr <= '0;
                        end
                    end
                end
                CMP: begin
                    if (store) begin
                        better_neighbor_count <= better_neighbor_count + ONE;
                    end
                    if (!last) begin
                        idx      <= idx + ONE;
                        mem_addr <= idx + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Index storage is deliberately left unreset
    always_ff @(posedge clock) begin
        if (store) begin
            slots[better_neighbor_count[AW-1:0]] <= idx;
        end
    end

endmodule

// File: tb/tb_better_neighbor_scan.sv
// Self-checking bench for better_neighbor_scan: table-driven scans plus saturation, held-start and mid-scan reset sequences.
// Expectations follow the SCAN_TIE_BETTER_EN macro when it is defined.
module tb_better_neighbor_scan;

    logic        clock;
    logic        nreset;
    logic        start_scan;
    logic [15:0] neighbor_total;
    logic [15:0] current_cost;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] better_neighbor_count;
    logic        done_scan;
    logic [3:0]  buf_index;
    logic [15:0] buf_addr;

    logic [15:0] tb_mem [32];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SCAN_TIE_BETTER_EN
    localparam bit TIE = 1'b1;
`else
    localparam bit TIE = 1'b0;
`endif

    better_neighbor_scan #(.DATA_W(16), .BUF_DEPTH(16)) dut (
        .clock                 (clock),
        .nreset                (nreset),
        .start_scan            (start_scan),
        .neighbor_total        (neighbor_total),
        .current_cost          (current_cost),
        .mem_rd                (mem_rd),
        .mem_addr              (mem_addr),
        .mem_data              (mem_data),
        .better_neighbor_count (better_neighbor_count),
        .done_scan             (done_scan),
        .buf_index             (buf_index),
        .buf_addr              (buf_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cost memory: data appears in the cycle after the read strobe
    always @(posedge clock) begin
        if (mem_rd) mem_data <= tb_mem[mem_addr[4:0]];
    end

    typedef struct {
        logic [15:0]       cost;
        logic [15:0]       total;
        logic [7:0][15:0]  mem;     // element 0 is the rightmost literal
        int                cnt_s;
        logic [7:0][15:0]  buf_s;
        int                cnt_t;
        logic [7:0][15:0]  buf_t;
        int                lat;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_scan(input logic [15:0] cost, input logic [15:0] total,
                            output int lat, output bit rd_ok);
        int  k;
        bit  exp_rd;
        @(negedge clock);
        current_cost   = cost;
        neighbor_total = total;
        start_scan     = 1'b1;
        @(posedge clock);
        #1;
        start_scan = 1'b0;
        k     = 0;
        rd_ok = 1'b1;
        while (done_scan !== 1'b1 && k < 200) begin
            exp_rd = (k % 2 == 0) && (k < 2 * int'(total));
            if (mem_rd !== exp_rd) rd_ok = 1'b0;
            if (exp_rd && mem_addr !== 16'(k / 2)) rd_ok = 1'b0;
            @(posedge clock);
            #1;
            k++;
        end
        lat = (done_scan === 1'b1) ? k : -1;
    endtask

    task automatic check_buf(input string name, input int cnt, input logic [15:0][15:0] exp_buf);
        for (int j = 0; j < cnt; j++) begin
            buf_index = 4'(j);
            #1;
            check($sformatf("%s buf[%0d]", name, j), 32'(buf_addr), 32'(exp_buf[j]));
        end
    endtask

    task automatic run_vector(input int id, input vec_t v);
        int                lat;
        bit                rd_ok;
        int                cnt;
        logic [15:0][15:0] eb;
        string             nm;
        nm = $sformatf("vec%0d", id);
        for (int j = 0; j < 32; j++) tb_mem[j] = (j < 8) ? v.mem[j] : 16'd0;
        cnt = TIE ? v.cnt_t : v.cnt_s;
        eb  = '0;
        for (int j = 0; j < 8; j++) eb[j] = TIE ? v.buf_t[j] : v.buf_s[j];
        run_scan(v.cost, v.total, lat, rd_ok);
        check({nm, " latency"}, 32'(lat), 32'(v.lat));
        check({nm, " rd_pattern"}, 32'(rd_ok), 32'd1);
        check({nm, " count"}, 32'(better_neighbor_count), 32'(cnt));
        if (v.total != 16'd0)
            check({nm, " addr_hold"}, 32'(mem_addr), 32'(v.total - 16'd1));
        check_buf(nm, cnt, eb);
        @(posedge clock);
        #1;
        check({nm, " done_width"}, 32'(done_scan), 32'd0);
        check({nm, " count_hold"}, 32'(better_neighbor_count), 32'(cnt));
    endtask

    initial begin
        int   lat;
        bit   rd_ok;
        int   pulses;
        int   first_done;
        int   second_done;
        bit   done_in_reset;
        logic [15:0][15:0] eb;

        nreset         = 1'b0;
        start_scan     = 1'b0;
        neighbor_total = '0;
        current_cost   = '0;
        buf_index      = '0;
        mem_data       = '0;
        for (int j = 0; j < 32; j++) tb_mem[j] = '0;

        // {cost, total, mem, strict count, strict buf, tie count, tie buf, latency}
        vecs[0] = '{16'd50, 16'd4, {16'd0,16'd0,16'd0,16'd0,16'd10,16'd50,16'd40,16'd60},
                    2, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd3,16'd1},
                    3, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd3,16'd2,16'd1}, 9};
        vecs[1] = '{16'd7, 16'd0, '0, 0, '0, 0, '0, 1};
        vecs[2] = '{16'd4, 16'd3, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd2,16'd1,16'd3},
                    3, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd2,16'd1,16'd0},
                    3, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd2,16'd1,16'd0}, 7};
        vecs[3] = '{16'd10, 16'd5, {16'd0,16'd0,16'd0,16'd14,16'd13,16'd12,16'd11,16'd10},
                    0, '0, 1, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd0}, 11};
        vecs[4] = '{16'd0, 16'd3, '0, 0, '0,
                    3, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd2,16'd1,16'd0}, 7};
        vecs[5] = '{16'hFFFF, 16'd2, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'hFFFF,16'hFFFE},
                    1, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd0},
                    2, {16'd0,16'd0,16'd0,16'd0,16'd0,16'd0,16'd1,16'd0}, 5};

        #1;
        check("reset mem_rd", 32'(mem_rd), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset count", 32'(better_neighbor_count), 32'd0);
        check("reset done", 32'(done_scan), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        nreset = 1'b1;

        for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);

        // Saturation: 20 neighbours all cheaper, only the first 16 indices kept
        for (int j = 0; j < 32; j++) tb_mem[j] = '0;
        run_scan(16'd5, 16'd20, lat, rd_ok);
        check("sat latency", 32'(lat), 32'd41);
        check("sat rd_pattern", 32'(rd_ok), 32'd1);
        check("sat count", 32'(better_neighbor_count), 32'd16);
        for (int j = 0; j < 16; j++) eb[j] = 16'(j);
        check_buf("sat", 16, eb);

        // start_scan held high across two back-to-back scans
        tb_mem[0] = 16'd1; tb_mem[1] = 16'd1; tb_mem[2] = 16'd1;
        @(negedge clock);
        current_cost   = 16'd5;
        neighbor_total = 16'd3;
        start_scan     = 1'b1;
        pulses      = 0;
        first_done  = -1;
        second_done = -1;
        for (int e = 0; e < 16; e++) begin
            @(posedge clock);
            #1;
            if (done_scan === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = e;
                else second_done = e;
            end
            if (e == 7) check("held count_first", 32'(better_neighbor_count), 32'd3);
            if (e == 8) begin
                check("held count_cleared", 32'(better_neighbor_count), 32'd0);
                check("held restart_rd", 32'(mem_rd), 32'd1);
            end
        end
        start_scan = 1'b0;
        check("held pulses", 32'(pulses), 32'd2);
        check("held first_done", 32'(first_done), 32'd7);
        check("held second_done", 32'(second_done), 32'd15);
        check("held count_final", 32'(better_neighbor_count), 32'd3);
        repeat (2) @(posedge clock);

        // Reset asserted during the second CMP of a T=4 scan
        tb_mem[0] = 16'd10; tb_mem[1] = 16'd60; tb_mem[2] = 16'd70; tb_mem[3] = 16'd80;
        @(negedge clock);
        current_cost   = 16'd50;
        neighbor_total = 16'd4;
        start_scan     = 1'b1;
        @(posedge clock);
        #1;
        start_scan = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst pre_count", 32'(better_neighbor_count), 32'd1);
        check("rst pre_addr", 32'(mem_addr), 32'd1);
        nreset = 1'b0;
        #1;
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst count", 32'(better_neighbor_count), 32'd0);
        check("rst done", 32'(done_scan), 32'd0);
        done_in_reset = 1'b0;
        for (int e = 0; e < 12; e++) begin
            if (e == 3) begin
                @(negedge clock);
                nreset = 1'b1;
            end
            @(posedge clock);
            #1;
            if (done_scan !== 1'b0) done_in_reset = 1'b1;
        end
        check("rst no_done", 32'(done_in_reset), 32'd0);
        run_vector(6, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/better_neighbor_scan.md
BETTER_NEIGHBOR_SCAN -- requirements
Module: better_neighbor_scan

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of cost, address and count values.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 16, giving the number of better-neighbour index slots; it SHALL be a power of two.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port nreset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start_scan, input, 1 bit: request to begin a scan.
REQ-006 The block SHALL have port neighbor_total, input, DATA_W bits: number of neighbours to scan; sampled at start.
REQ-007 The block SHALL have port current_cost, input, DATA_W bits: cost of the current solution; sampled at start.
REQ-008 The block SHALL have port mem_rd, output, 1 bit: cost-memory read strobe.
REQ-009 The block SHALL have port mem_addr, output, DATA_W bits: neighbour index being read.
REQ-010 The block SHALL have port mem_data, input, DATA_W bits: neighbour cost, valid in the cycle after mem_rd.
REQ-011 The block SHALL have port better_neighbor_count, output, DATA_W bits: number of stored better neighbours, which feeds the random-address stage.
REQ-012 The block SHALL have port done_scan, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port buf_index, input, log2(BUF_DEPTH) bits: buffer read select.
REQ-014 The block SHALL have port buf_addr, output, DATA_W bits: stored neighbour index at buf_index (combinational read).

Function
REQ-015 The FSM SHALL have states IDLE, READ, CMP and DONE.
REQ-016 In IDLE, with start_scan=1, the block SHALL latch neighbor_total and current_cost, clear idx and better_neighbor_count, and go to READ; if neighbor_total=0 it SHALL go to DONE instead.
REQ-017 In READ, the block SHALL drive mem_rd=1 and mem_addr=idx for exactly one cycle, then go to CMP.
REQ-018 In CMP, mem_data<latched cost SHALL count as better.
REQ-019 On a better result with count<BUF_DEPTH, the block SHALL write idx into buf[count] and increment count.
REQ-020 On a better result with count=BUF_DEPTH, the block SHALL discard it; count SHALL saturate at BUF_DEPTH.
REQ-021 In CMP, if idx=total-1 the block SHALL go to DONE; otherwise it SHALL increment idx and go to READ.
REQ-022 In DONE, done_scan=1 for exactly one cycle, then the block SHALL go to IDLE.
REQ-023 Latency: for total T>0, done_scan SHALL be high in the cycle beginning 2T+1 edges after the edge sampling start_scan; for T=0, 1 edge after.
REQ-024 start_scan SHALL be ignored in READ, CMP and DONE; there is no abort.
REQ-025 mem_rd SHALL be 0 and mem_addr SHALL hold its last value outside READ.
REQ-026 better_neighbor_count and buffer contents SHALL hold from DONE until the next accepted start.
REQ-027 buf_index>=count SHALL return the stale buffer contents; consumers index only below count.
REQ-028 idx compare and increment SHALL be DATA_W unsigned; T=2^DATA_W-1 is legal, and idx SHALL not wrap before DONE.

Reset
REQ-029 On nreset=0, asynchronously: state=IDLE, mem_rd=0, mem_addr=0, better_neighbor_count=0, done_scan=0, idx=0.
REQ-030 Buffer storage SHALL NOT be reset; buf_addr is undefined until written.
REQ-031 Reset asserted mid-scan SHALL abandon the scan with no done_scan pulse.
REQ-032 After reset deassertion, the first start_scan SHALL be accepted on the following rising edge.

Configuration
REQ-033 With macro SCAN_TIE_BETTER_EN defined, the CMP test SHALL be mem_data<=latched cost (ties count as better).
REQ-034 Without SCAN_TIE_BETTER_EN, the CMP test SHALL be strict mem_data<latched cost.

Verification
REQ-035 Scenario: cost=50, T=4, mem costs {60,40,50,10} -> count=2, buf[0]=1, buf[1]=3, done_scan 9 edges after start; with SCAN_TIE_BETTER_EN -> count=3, buf={1,2,3}.
REQ-036 Scenario: T=0 -> done_scan one edge after start, count=0, mem_rd never asserted.
REQ-037 Scenario: T=20, all costs 0, cost=5 -> count=16 (saturated), buf[k]=k for k=0..15.
REQ-038 Scenario: start_scan held high through a scan with T=3 -> single done_scan pulse, then a new scan starts from IDLE with count cleared.
REQ-039 Scenario: nreset pulsed low during the second CMP of a T=4 scan -> all outputs 0 immediately, no done_scan, next start runs normally.
REQ-040 Scenario: costs {3,1,2} with cost=4 -> mem_addr sequence 0,1,2 with mem_rd high in alternating cycles, count=3.
